// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destination tags over DEPTH stages and
// produces operand forwarding selects, load-use stall/bubble, branch fetch flush and perf counters.
module hazard_ctrl #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZREG     = 31,
  parameter int CNT_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dec_valid,
  input  logic [AW-1:0]                  dec_rs1,
  input  logic [AW-1:0]                  dec_rs2,
  input  logic                           dec_rs1_used,
  input  logic                           dec_rs2_used,
  input  logic [AW-1:0]                  dec_rd,
  input  logic                           dec_wr,
  input  logic                           dec_load,
  input  logic                           br_taken,
  output logic                           stall,
  output logic                           bubble,
  output logic                           flush_if,
  output logic [$clog2(DEPTH+1)-1:0]     fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]     fwd_b,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               flush_cnt
);

  localparam int FW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] ZR = AW'(ZREG);

  logic [DEPTH:1]         valid_q, valid_d;
  logic [DEPTH:1]         wr_q, wr_d;
  logic [DEPTH:1]         load_q, load_d;
  logic [DEPTH:1][AW-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

  logic [DEPTH:1] live;
  logic           hazard;
  logic [FW-1:0]  sel_a, sel_b;
  logic           accept;

  always_comb begin
    live   = '0;
    hazard = 1'b0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      live[k] = valid_q[k] && wr_q[k] && (rd_q[k] != ZR);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      if (k <= LOAD_LAT && live[k] && load_q[k] &&
          ((dec_rs1_used && rd_q[k] == dec_rs1) || (dec_rs2_used && rd_q[k] == dec_rs2))) begin
        hazard = 1'b1;
      end
    end
    // Walk oldest to youngest so the youngest matching stage wins.
    for (int k = DEPTH; k >= 1; k--) begin
      if (live[k] && !(load_q[k] && k <= LOAD_LAT)) begin
        if (dec_rs1_used && rd_q[k] == dec_rs1) sel_a = FW'(k);
        if (dec_rs2_used && rd_q[k] == dec_rs2) sel_b = FW'(k);
      end
    end
  end

  assign stall     = !rst && dec_valid && hazard;
  assign bubble    = stall;
  assign flush_if  = !rst && dec_valid && br_taken && !stall;
  assign fwd_a     = rst ? '0 : sel_a;
  assign fwd_b     = rst ? '0 : sel_b;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  assign accept = dec_valid && !stall;

  always_comb begin
    valid_d = valid_q;
    wr_d    = wr_q;
    load_d  = load_q;
    rd_d    = rd_q;
    for (int k = DEPTH; k >= 2; k--) begin
      valid_d[k] = valid_q[k-1];
      wr_d[k]    = wr_q[k-1];
      load_d[k]  = load_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
    // A stalled or empty decode slot enters the pipe as a bubble; nothing freezes.
    valid_d[1] = accept;
    wr_d[1]    = accept && dec_wr;
    load_d[1]  = accept && dec_load;
    rd_d[1]    = accept ? dec_rd : '0;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != '1)    stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_if && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      wr_q        <= '0;
      load_q      <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      wr_q        <= wr_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes expected outputs from an instruction-history
// model, a negedge monitor pops and compares; directed scenarios add fixed-value checks.
module tb_hazard_ctrl;
  localparam int AW = 5, DEPTH = 3, LOAD_LAT = 1, ZREG = 31, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dec_valid = 0, dec_rs1_used = 0, dec_rs2_used = 0, dec_wr = 0, dec_load = 0, br_taken = 0;
  logic [AW-1:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic stall, bubble, flush_if;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZREG(ZREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd), .dec_wr(dec_wr),
    .dec_load(dec_load), .br_taken(br_taken), .stall(stall), .bubble(bubble), .flush_if(flush_if),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  typedef struct { bit v; int rd; bit wr; bit ld; } instr_t;
  typedef struct { int stl; int bub; int fl; int fa; int fb; int sc; int fc; } exp_t;

  instr_t hist[$];   // hist[i] = instruction that entered the pipe i+1 cycles ago
  exp_t   sb[$];
  int     m_scnt = 0, m_fcnt = 0;
  int     checks = 0, failures = 0;

  int first_stall, first_bubble, first_flush, last_fa, last_fb, last_flush, n_stalls;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writes_live(input instr_t e);
    return e.v && e.wr && e.rd != ZREG;
  endfunction

  // Source of operand: age of youngest live producer, unless it is a load still too young.
  function automatic int src_of(input int rs, input bit used);
    if (!used) return 0;
    for (int age = 1; age <= DEPTH; age++) begin
      if (writes_live(hist[age-1]) && hist[age-1].rd == rs)
        return (hist[age-1].ld && age <= LOAD_LAT) ? 0 : age;
    end
    return 0;
  endfunction

  function automatic bit needs_wait(input int rs, input bit used);
    if (!used) return 0;
    for (int age = 1; age <= LOAD_LAT; age++)
      if (writes_live(hist[age-1]) && hist[age-1].ld && hist[age-1].rd == rs) return 1;
    return 0;
  endfunction

  // One decode cycle: returns the model's stall decision; the monitor does the full comparison.
  task automatic cycle(input bit r, input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit br, output bit exp_stall);
    exp_t e;
    instr_t ni;
    rst = r; dec_valid = v; dec_rs1 = AW'(rs1); dec_rs2 = AW'(rs2);
    dec_rs1_used = u1; dec_rs2_used = u2; dec_rd = AW'(rd); dec_wr = wr; dec_load = ld; br_taken = br;
    e.stl = (!r && v && (needs_wait(rs1, u1) || needs_wait(rs2, u2))) ? 1 : 0;
    e.bub = e.stl;
    e.fl  = (!r && v && br && e.stl == 0) ? 1 : 0;
    e.fa  = r ? 0 : src_of(rs1, u1);
    e.fb  = r ? 0 : src_of(rs2, u2);
    e.sc  = m_scnt;
    e.fc  = m_fcnt;
    sb.push_back(e);
    exp_stall = (e.stl != 0);
    #1;
    if (first_stall < 0) begin
      first_stall = int'(stall); first_bubble = int'(bubble); first_flush = int'(flush_if);
    end
    last_fa = int'(fwd_a); last_fb = int'(fwd_b); last_flush = int'(flush_if);
    @(posedge clk);
    if (r) begin
      foreach (hist[i]) hist[i] = '{0, 0, 0, 0};
      m_scnt = 0; m_fcnt = 0;
    end else begin
      ni = '{v && e.stl == 0, rd, wr, ld};
      if (!ni.v) ni = '{0, 0, 0, 0};
      hist.push_front(ni);
      void'(hist.pop_back());
      if (e.stl != 0 && m_scnt < CNT_MAX) m_scnt++;
      if (e.fl != 0 && m_fcnt < CNT_MAX) m_fcnt++;
    end
    #1;
  endtask

  // Present an instruction until decode accepts it (IF/ID holds it while stalled).
  task automatic issue(input bit r, input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit br);
    bit s;
    first_stall = -1; n_stalls = 0;
    for (int a = 0; a < 8; a++) begin
      cycle(r, v, rs1, rs2, u1, u2, rd, wr, ld, br, s);
      if (!s) break;
      n_stalls++;
    end
  endtask

  task automatic nop();           issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_reset();      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input int rd, input int rs1, input int rs2); issue(0, 1, rs1, rs2, 1, 1, rd, 1, 0, 0); endtask
  task automatic ldur(input int rd, input int rn); issue(0, 1, rn, 0, 1, 0, rd, 1, 1, 0); endtask
  task automatic cbz(input int rt); issue(0, 1, rt, 0, 1, 0, 0, 0, 0, 1); endtask
  task automatic drain(); repeat (DEPTH) nop(); endtask

  exp_t m;
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        m = sb.pop_front();
        chk("stall", int'(stall), m.stl);
        chk("bubble", int'(bubble), m.bub);
        chk("flush_if", int'(flush_if), m.fl);
        chk("fwd_a", int'(fwd_a), m.fa);
        chk("fwd_b", int'(fwd_b), m.fb);
        chk("stall_cnt", int'(stall_cnt), m.sc);
        chk("flush_cnt", int'(flush_cnt), m.fc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit r, v, u1, u2, wr, ld, br;
    int rs1, rs2, rd;
    for (int i = 0; i < DEPTH; i++) hist.push_back('{0, 0, 0, 0});
    @(posedge clk); #1;
    do_reset();
    chk("reset_stall_cnt", int'(stall_cnt), 0);

    alu(1, 2, 3); alu(2, 1, 3);
    chk("alu_b2b_fwd_a", last_fa, 1); chk("alu_b2b_stalls", n_stalls, 0);
    drain();
    alu(1, 2, 3); nop(); alu(2, 1, 3);
    chk("alu_gap1_fwd_a", last_fa, 2);
    drain();
    alu(1, 2, 3); nop(); nop(); alu(2, 1, 3);
    chk("alu_gap2_fwd_a", last_fa, 3);
    drain();

    ldur(5, 0); alu(6, 5, 7);
    chk("ld_use_first_stall", first_stall, 1); chk("ld_use_first_bubble", first_bubble, 1);
    chk("ld_use_stalls", n_stalls, 1); chk("ld_use_fwd_a", last_fa, 2);
    chk("ld_use_stall_cnt", int'(stall_cnt), 1);
    drain();

    alu(4, 0, 0); alu(4, 0, 0); alu(8, 4, 4);
    chk("youngest_fwd_a", last_fa, 1); chk("same_src_fwd_b", last_fb, 1);
    drain();
    alu(31, 1, 2); alu(9, 31, 31);
    chk("zreg_fwd_a", last_fa, 0); chk("zreg_fwd_b", last_fb, 0);
    alu(1, 1, 1); alu(1, 1, 1);
    chk("self_src_fwd_a", last_fa, 1); chk("self_src_stalls", n_stalls, 0);
    drain();

    do_reset();
    cbz(9);
    chk("br_flush", last_flush, 1); chk("br_stalls", n_stalls, 0);
    chk("br_flush_cnt", int'(flush_cnt), 1);
    drain();
    ldur(5, 0); cbz(5);
    chk("br_ld_first_flush", first_flush, 0); chk("br_ld_stalls", n_stalls, 1);
    chk("br_ld_final_flush", last_flush, 1);
    drain();

    do_reset();
    repeat (20) begin ldur(5, 0); alu(6, 5, 7); end
    chk("sat_stall_cnt", int'(stall_cnt), CNT_MAX);
    drain();

    ldur(5, 0);
    issue(1, 1, 5, 7, 1, 1, 6, 1, 0, 0);
    chk("rst_mid_stall", first_stall, 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0); chk("rst_flush_cnt", int'(flush_cnt), 0);
    alu(6, 5, 7);
    chk("rst_reader_fwd_a", last_fa, 0); chk("rst_reader_stalls", n_stalls, 0);

    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 5) != 0);
      rs1 = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 7);
      rs2 = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 7);
      rd  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 7);
      u1  = ($urandom_range(0, 4) != 0);
      u2  = ($urandom_range(0, 2) != 0);
      wr  = ($urandom_range(0, 4) != 0);
      ld  = wr && ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 5) == 0);
      issue(r, v, rs1, rs2, u1, u2, rd, wr, ld, br);
    end
    rst = 0; dec_valid = 0; br_taken = 0;

    for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
